ram_arbiter: RTL and testbench

- Shares one distributed data RAM (10-bit byte address, big-endian word/byte write, asynchronous 32-bit read) between two requesters: port 0 = core load/store unit, port 1 = UART program loader.
- Arbitrates valid/ready requests and sequences each access through a 3-state FSM.
- Returns a one-cycle response pulse to the winning requester.
- Sits between the memory stage and the RAM instance.

---
 rtl/ram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one asynchronous-read data RAM between the core
//             load/store unit (port 0) and the UART program loader (port 1).
//             Requests are arbitrated in IDLE, issued to the RAM for one
//             cycle, then answered with a one-cycle response pulse.
//  Options  : RAM_ARB_PERF_EN adds per-port grant and wait counters.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic              req0_byte,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic              req1_byte,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              ram_we,
  output logic              ram_wordorbyte,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [31:0]       ram_di,
  input  logic [31:0]       ram_dout
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_wait0,
  output logic [31:0]       perf_wait1
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                sel_any;
  logic                sel_port;
  logic                accept;

  // Pick the candidate port: a lone requester wins, ties go by policy
  always_comb begin
    sel_any  = req0_valid | req1_valid;
    sel_port = 1'b0;
    if (req0_valid && req1_valid) begin
      if (ROUND_ROBIN != 0) begin
        sel_port = ~last_grant_q;
      end else begin
        sel_port = 1'b0;
      end
    end else begin
      sel_port = req1_valid;
    end
  end

  // Only an idle arbiter out of reset offers a handshake, to one port only
  assign accept     = rstn && (state_q == IDLE) && sel_any;
  assign req0_ready = accept && !sel_port;
  assign req1_ready = accept && sel_port;

  // Next-state and latch logic for the IDLE -> ISSUE -> RESP sequence
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    byte_d       = byte_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = sel_port;
          last_grant_d = sel_port;
          we_d         = sel_port ? req1_we    : req0_we;
          byte_d       = sel_port ? req1_byte  : req0_byte;
          addr_d       = sel_port ? req1_addr  : req0_addr;
          wdata_d      = sel_port ? req1_wdata : req0_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // RAM read data is combinational; capture it while the address is
        // presented. The addressed byte sits in the top lane (big-endian).
        if (we_q) begin
          rdata_d = 32'd0;
        end else if (byte_q) begin
          rdata_d = {24'd0, ram_dout[31:24]};
        end else begin
          rdata_d = ram_dout;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // RAM side: write strobe only in ISSUE and never while reset is asserted
  assign ram_we         = rstn && (state_q == ISSUE) && we_q;
  assign ram_wordorbyte = byte_q;
  assign ram_raddr      = addr_q;
  assign ram_waddr      = addr_q;
  assign ram_di         = wdata_q;

  // Response pulse goes to the owner only; data is zero outside the pulse
  assign rsp0_valid = rstn && (state_q == RESP) && !owner_q;
  assign rsp1_valid = rstn && (state_q == RESP) && owner_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : 32'd0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : 32'd0;

`ifdef RAM_ARB_PERF_EN
  logic [31:0] perf_grant0_q, perf_grant0_d;
  logic [31:0] perf_grant1_q, perf_grant1_d;
  logic [31:0] perf_wait0_q, perf_wait0_d;
  logic [31:0] perf_wait1_q, perf_wait1_d;

  // Grant counts follow handshakes; wait counts follow stalled valids
  always_comb begin
    perf_grant0_d = perf_grant0_q + {31'd0, (req0_valid && req0_ready)};
    perf_grant1_d = perf_grant1_q + {31'd0, (req1_valid && req1_ready)};
    perf_wait0_d  = perf_wait0_q  + {31'd0, (req0_valid && !req0_ready)};
    perf_wait1_d  = perf_wait1_q  + {31'd0, (req1_valid && !req1_ready)};
  end

  // Free-running counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_grant0_q <= 32'd0;
      perf_grant1_q <= 32'd0;
      perf_wait0_q  <= 32'd0;
      perf_wait1_q  <= 32'd0;
    end else begin
      perf_grant0_q <= perf_grant0_d;
      perf_grant1_q <= perf_grant1_d;
      perf_wait0_q  <= perf_wait0_d;
      perf_wait1_q  <= perf_wait1_d;
    end
  end

  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_wait0  = perf_wait0_q;
  assign perf_wait1  = perf_wait1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter: directed scenarios followed
//             by randomized traffic, compared against a transaction-level
//             reference model. Honours RAM_ARB_PERF_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int RR = 1;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0, b0 = 1'b0, b1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [31:0]   wd0 = '0, wd1 = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0]   rsp0_rdata, rsp1_rdata;
  logic          ram_we, ram_wordorbyte;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [31:0]   ram_di, ram_dout;

  logic          fp_r0, fp_r1, fp_s0, fp_s1, fp_we, fp_wb;
  logic [31:0]   fp_d0, fp_d1, fp_di;
  logic [AW-1:0] fp_ra, fp_wa;
`ifdef RAM_ARB_PERF_EN
  logic [31:0]   pg0, pg1, pw0, pw1, fpg0, fpg1, fpw0, fpw1;
`endif

  ram_arbiter #(.ROUND_ROBIN(RR), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_we(we0), .req0_byte(b0),
    .req0_addr(a0), .req0_wdata(wd0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_we(we1), .req1_byte(b1),
    .req1_addr(a1), .req1_wdata(wd1),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_wordorbyte(ram_wordorbyte),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_di(ram_di),
    .ram_dout(ram_dout)
`ifdef RAM_ARB_PERF_EN
    , .perf_grant0(pg0), .perf_grant1(pg1), .perf_wait0(pw0), .perf_wait1(pw1)
`endif
  );

  // Fixed-priority instance, both ports permanently requesting word loads
  ram_arbiter #(.ROUND_ROBIN(0), .ADDR_W(AW)) dut_fp (
    .clk(clk), .rstn(rstn),
    .req0_valid(1'b1), .req0_ready(fp_r0), .req0_we(1'b0), .req0_byte(1'b0),
    .req0_addr(10'h004), .req0_wdata(32'd0),
    .req1_valid(1'b1), .req1_ready(fp_r1), .req1_we(1'b0), .req1_byte(1'b0),
    .req1_addr(10'h008), .req1_wdata(32'd0),
    .rsp0_valid(fp_s0), .rsp0_rdata(fp_d0),
    .rsp1_valid(fp_s1), .rsp1_rdata(fp_d1),
    .ram_we(fp_we), .ram_wordorbyte(fp_wb),
    .ram_raddr(fp_ra), .ram_waddr(fp_wa), .ram_di(fp_di),
    .ram_dout(32'hA5A5A5A5)
`ifdef RAM_ARB_PERF_EN
    , .perf_grant0(fpg0), .perf_grant1(fpg1), .perf_wait0(fpw0), .perf_wait1(fpw1)
`endif
  );

  // Environment RAM with guard bytes past the top address
  bit [7:0] mem [0:1026];
  assign ram_dout = {mem[int'(ram_raddr)], mem[int'(ram_raddr) + 1],
                     mem[int'(ram_raddr) + 2], mem[int'(ram_raddr) + 3]};
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      if (ram_wordorbyte) begin
        mem[int'(ram_waddr)] <= ram_di[7:0];
      end else begin
        mem[int'(ram_waddr)]     <= ram_di[31:24];
        mem[int'(ram_waddr) + 1] <= ram_di[23:16];
        mem[int'(ram_waddr) + 2] <= ram_di[15:8];
        mem[int'(ram_waddr) + 3] <= ram_di[7:0];
      end
    end
  end

  int ncmp = 0;
  int nerr = 0;

  // Reference model: transaction view of the arbiter
  bit [7:0]    ref_mem [0:1026];
  int          cyc = 0, next_free = 0, fp_base = 0;
  bit          last_g = 1'b1, pend = 1'b0, p_port, p_we, p_byte;
  int          p_acc;
  logic [AW-1:0] p_addr, lat_addr = '0;
  logic [31:0] p_wd, p_rd;
  int          m_g0 = 0, m_g1 = 0, m_w0 = 0, m_w1 = 0;

  // Observations of the DUT used to steer stimulus and directed checks
  bit          d_hs0, d_hs1;
  int          we_cnt = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
  logic [31:0] rsp_dat0 = '0, rsp_dat1 = '0;
  int          grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  task automatic tick();
    bit e_r0, e_r1, e_rsp, e_f0, e_fs;
    int k, a;
    @(negedge clk);
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (rstn && cyc >= next_free) begin
      if (v0 && v1) begin
        if (RR != 0) begin
          e_r0 = last_g;
          e_r1 = ~last_g;
        end else begin
          e_r0 = 1'b1;
        end
      end else if (v0) begin
        e_r0 = 1'b1;
      end else if (v1) begin
        e_r1 = 1'b1;
      end
    end
    chk("req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(req1_ready), 32'(e_r1));
    chk("ram_we", 32'(ram_we), 32'(rstn && pend && cyc == p_acc + 1 && p_we));
    if (rstn && pend && cyc == p_acc + 1) begin
      chk("ram_wordorbyte", 32'(ram_wordorbyte), 32'(p_byte));
      chk("ram_di", ram_di, p_wd);
    end
    if (cyc > 0) begin
      chk("ram_raddr", 32'(ram_raddr), 32'(lat_addr));
      chk("ram_waddr", 32'(ram_waddr), 32'(lat_addr));
    end
    e_rsp = rstn && pend && cyc == p_acc + 2;
    chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rsp && !p_port));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rsp && p_port));
    if (e_rsp) chk(p_port ? "rsp1_rdata" : "rsp0_rdata", p_port ? rsp1_rdata : rsp0_rdata, p_rd);

    e_f0 = 1'b0;
    e_fs = 1'b0;
    if (rstn && cyc >= fp_base) begin
      k    = cyc - fp_base;
      e_f0 = (k % 3 == 0);
      e_fs = (k >= 2) && (k % 3 == 2);
    end
    chk("fp_req0_ready", 32'(fp_r0), 32'(e_f0));
    chk("fp_req1_ready", 32'(fp_r1), 32'd0);
    chk("fp_rsp0_valid", 32'(fp_s0), 32'(e_fs));
    chk("fp_rsp1_valid", 32'(fp_s1), 32'd0);
    if (e_fs) chk("fp_rsp0_rdata", fp_d0, 32'hA5A5A5A5);
`ifdef RAM_ARB_PERF_EN
    if (cyc > 0) begin
      chk("perf_grant0", pg0, m_g0);
      chk("perf_grant1", pg1, m_g1);
      chk("perf_wait0", pw0, m_w0);
      chk("perf_wait1", pw1, m_w1);
    end
`endif

    d_hs0 = (req0_ready === 1'b1) && v0;
    d_hs1 = (req1_ready === 1'b1) && v1;
    if (d_hs0) grants.push_back(0);
    if (d_hs1) grants.push_back(1);
    if (ram_we === 1'b1) we_cnt++;
    if (rsp0_valid === 1'b1) begin rsp_cnt0++; rsp_dat0 = rsp0_rdata; end
    if (rsp1_valid === 1'b1) begin rsp_cnt1++; rsp_dat1 = rsp1_rdata; end

    if (!rstn) begin
      pend      = 1'b0;
      next_free = cyc + 1;
      fp_base   = cyc + 1;
      last_g    = 1'b1;
      lat_addr  = '0;
      m_g0 = 0; m_g1 = 0; m_w0 = 0; m_w1 = 0;
    end else begin
      if (v0 && !e_r0) m_w0++;
      if (v1 && !e_r1) m_w1++;
      if (pend && cyc == p_acc + 1) begin
        a = int'(p_addr);
        if (p_we) begin
          p_rd = 32'd0;
          if (p_byte) begin
            ref_mem[a] = p_wd[7:0];
          end else begin
            ref_mem[a] = p_wd[31:24]; ref_mem[a+1] = p_wd[23:16];
            ref_mem[a+2] = p_wd[15:8]; ref_mem[a+3] = p_wd[7:0];
          end
        end else if (p_byte) begin
          p_rd = {24'd0, ref_mem[a]};
        end else begin
          p_rd = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
        end
      end
      if (pend && cyc == p_acc + 2) pend = 1'b0;
      if (e_r0 || e_r1) begin
        p_port    = e_r1;
        p_we      = e_r1 ? we1 : we0;
        p_byte    = e_r1 ? b1 : b0;
        p_addr    = e_r1 ? a1 : a0;
        p_wd      = e_r1 ? wd1 : wd0;
        p_acc     = cyc;
        pend      = 1'b1;
        next_free = cyc + 3;
        last_g    = e_r1;
        lat_addr  = p_addr;
        if (e_r1) m_g1++; else m_g0++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the DUT accepts it
  task automatic do_req(input bit port, input bit we, input bit byt,
                        input logic [AW-1:0] a, input logic [31:0] d);
    int n = 0;
    if (port) begin v1 = 1'b1; we1 = we; b1 = byt; a1 = a; wd1 = d; end
    else      begin v0 = 1'b1; we0 = we; b0 = byt; a0 = a; wd0 = d; end
    do begin
      tick();
      n++;
    end while (!(port ? d_hs1 : d_hs0) && n < 20);
    chk("handshake", 32'(port ? d_hs1 : d_hs0), 32'd1);
    if (port) v1 = 1'b0; else v0 = 1'b0;
  endtask

  int snap_we, snap_r0, snap_r1;

  initial begin
    // Reset
    rstn = 1'b0;
    repeat (3) tick();
    chk("reset_rsp0_rdata", rsp0_rdata, 32'd0);
    chk("reset_rsp1_rdata", rsp1_rdata, 32'd0);
    rstn = 1'b1;
    tick();

    // Port 0 word store
    snap_we = we_cnt;
    do_req(1'b0, 1'b1, 1'b0, 10'h010, 32'hDEADBEEF);
    repeat (2) tick();
    chk("store_we_pulses", 32'(we_cnt - snap_we), 32'd1);
    chk("store_rsp0_rdata", rsp_dat0, 32'd0);

    // Word and byte loads of the stored word
    do_req(1'b0, 1'b0, 1'b0, 10'h010, 32'd0);
    repeat (2) tick();
    chk("word_load", rsp_dat0, 32'hDEADBEEF);
    do_req(1'b0, 1'b0, 1'b1, 10'h011, 32'd0);
    repeat (2) tick();
    chk("byte_load", rsp_dat0, 32'h000000AD);

    // Port 1 byte store at the top address
    snap_r0 = rsp_cnt0;
    snap_r1 = rsp_cnt1;
    do_req(1'b1, 1'b1, 1'b1, 10'h3FF, 32'h12345678);
    repeat (2) tick();
    chk("p1_rsp_count", 32'(rsp_cnt1 - snap_r1), 32'd1);
    chk("p0_rsp_silent", 32'(rsp_cnt0 - snap_r0), 32'd0);
    chk("mem_3ff", 32'(mem[1023]), 32'h78);
    do_req(1'b1, 1'b0, 1'b0, 10'h3FF, 32'd0);
    repeat (2) tick();
    chk("wrap_word_load", rsp_dat1, 32'h78000000);

    // Continuous contention after reset: round-robin order
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    grants.delete();
    v0 = 1'b1; we0 = 1'b0; b0 = 1'b0; a0 = 10'h010; wd0 = '0;
    v1 = 1'b1; we1 = 1'b0; b1 = 1'b0; a1 = 10'h3FC; wd1 = '0;
    repeat (10) tick();
`ifdef RAM_ARB_PERF_EN
    @(negedge clk);
    chk("perf_grant0_rr", pg0, 32'd2);
    chk("perf_grant1_rr", pg1, 32'd2);
    chk("perf_wait_sum_rr", pw0 + pw1, 32'd16);
    @(posedge clk);
    #1;
`endif
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (3) tick();
    chk("rr_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_grant_order", 32'(grants[i]), 32'(i % 2));

    // Reset during the ISSUE cycle of a store
    snap_we = we_cnt;
    snap_r0 = rsp_cnt0;
    do_req(1'b0, 1'b1, 1'b0, 10'h020, 32'hCAFEF00D);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("rst_issue_no_we", 32'(we_cnt - snap_we), 32'd0);
    chk("rst_issue_no_rsp", 32'(rsp_cnt0 - snap_r0), 32'd0);
    do_req(1'b0, 1'b0, 1'b0, 10'h020, 32'd0);
    repeat (2) tick();
    chk("post_reset_load", rsp_dat0, 32'd0);
    chk("post_reset_rsp", 32'(rsp_cnt0 - snap_r0), 32'd1);

    // Randomized traffic with withdrawals and occasional resets
    for (int n = 0; n < 600; n++) begin
      if (d_hs0 || (v0 && $urandom_range(15) == 0)) v0 = 1'b0;
      else if (!v0 && $urandom_range(2) == 0) begin
        v0 = 1'b1; we0 = 1'($urandom); b0 = 1'($urandom);
        a0 = AW'($urandom); wd0 = $urandom;
      end
      if (d_hs1 || (v1 && $urandom_range(15) == 0)) v1 = 1'b0;
      else if (!v1 && $urandom_range(2) == 0) begin
        v1 = 1'b1; we1 = 1'($urandom); b1 = 1'($urandom);
        a1 = AW'($urandom); wd1 = $urandom;
      end
      rstn = ($urandom_range(79) != 0);
      tick();
    end
    rstn = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
